id_ex_pipeline_reg: RTL and testbench

//  ID/EX pipeline register directly upstream of the EX-stage ALU. It latches decoded operands and

---
 rtl/id_ex_pipeline_reg_pkg.sv | 59 +++++
 rtl/id_ex_pipeline_reg_load_use_detect.sv | 19 +
 rtl/id_ex_pipeline_reg.sv | 108 ++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared widths, control encodings and helpers for the ID/EX pipeline register.
// The ALU-select, write-back and branch codes are the ones the ALU and MEM/WB stages decode.
package id_ex_pipeline_reg_pkg;

   localparam int XLEN    = 32;
   localparam int REGADDR = 5;
   localparam int SELW    = 5;

   // ALU select = {func7[5], func7[0], func3}
   localparam logic [SELW-1:0] ALU_ADD  = 5'b00000;
   localparam logic [SELW-1:0] ALU_SUB  = 5'b10000;
   localparam logic [SELW-1:0] ALU_XOR  = 5'b00100;
   localparam logic [SELW-1:0] ALU_OR   = 5'b00110;
   localparam logic [SELW-1:0] ALU_AND  = 5'b00111;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [3:0] BR_NONE = 4'd0;

   typedef struct packed {
      logic               valid;
      logic [XLEN-1:0]    pc;
      logic [REGADDR-1:0] rs1;
      logic [REGADDR-1:0] rs2;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [REGADDR-1:0] rd;
      logic [SELW-1:0]    alu_select;
      logic               op1_sel;
      logic               op2_sel;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic [1:0]         wb_sel;
      logic [3:0]         branch_ctrl;
   } id_ex_t;

   function automatic id_ex_t bubble();
      id_ex_t b;
      b             = '0;
      b.alu_select  = ALU_ADD;
      b.wb_sel      = WB_ALU;
      b.branch_ctrl = BR_NONE;
      return b;
   endfunction

   // x0 is hardwired, so a WB write to it must never be forwarded.
   function automatic logic [XLEN-1:0] wb_bypass(input logic               wb_en,
                                                 input logic [REGADDR-1:0] wb_rd,
                                                 input logic [REGADDR-1:0] rs,
                                                 input logic [XLEN-1:0]    wb_data,
                                                 input logic [XLEN-1:0]    cur);
      return (wb_en && (wb_rd != '0) && (wb_rd == rs)) ? wb_data : cur;
   endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// Load-use detector: flags an ID instruction that reads the rd of a load now sitting in EX.
// A redirect (flush) kills the ID instruction, so no hazard is reported then.
module load_use_detect
   import id_ex_pipeline_reg_pkg::*;
(
   input  logic               ex_valid,
   input  logic               ex_mem_read,
   input  logic [REGADDR-1:0] ex_rd,
   input  logic               id_valid,
   input  logic [REGADDR-1:0] id_rs1,
   input  logic [REGADDR-1:0] id_rs2,
   input  logic               flush,
   output logic               hazard
);

   assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid && !flush;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register feeding the EX-stage ALU, with stall/flush/load-use bubble
// handling and write-back forwarding into both newly latched and held operands.
module id_ex_pipeline_reg
   import id_ex_pipeline_reg_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [REGADDR-1:0] in_rs1,
   input  logic [REGADDR-1:0] in_rs2,
   input  logic [XLEN-1:0]    in_rs1_data,
   input  logic [XLEN-1:0]    in_rs2_data,
   input  logic [XLEN-1:0]    in_imm,
   input  logic [REGADDR-1:0] in_rd,
   input  logic [SELW-1:0]    in_alu_select,
   input  logic               in_op1_sel,
   input  logic               in_op2_sel,
   input  logic               in_reg_write,
   input  logic               in_mem_read,
   input  logic               in_mem_write,
   input  logic [1:0]         in_wb_sel,
   input  logic [3:0]         in_branch_ctrl,
   input  logic               wb_write_en,
   input  logic [REGADDR-1:0] wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   output logic [XLEN-1:0]    alu_data1,
   output logic [XLEN-1:0]    alu_data2,
   output logic [SELW-1:0]    alu_select,
   output logic               out_valid,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_rs2_data,
   output logic [XLEN-1:0]    out_imm,
   output logic [REGADDR-1:0] out_rd,
   output logic               out_reg_write,
   output logic               out_mem_read,
   output logic               out_mem_write,
   output logic [1:0]         out_wb_sel,
   output logic [3:0]         out_branch_ctrl,
   output logic               load_use_hazard
);

   id_ex_t q;
   id_ex_t d;

   load_use_detect u_load_use_detect (
      .ex_valid    (q.valid),
      .ex_mem_read (q.mem_read),
      .ex_rd       (q.rd),
      .id_valid    (in_valid),
      .id_rs1      (in_rs1),
      .id_rs2      (in_rs2),
      .flush       (flush),
      .hazard      (load_use_hazard)
   );

   always_comb begin
      d             = '0;
      d.valid       = in_valid;
      d.pc          = in_pc;
      d.rs1         = in_rs1;
      d.rs2         = in_rs2;
      d.rs1_data    = wb_bypass(wb_write_en, wb_rd, in_rs1, wb_data, in_rs1_data);
      d.rs2_data    = wb_bypass(wb_write_en, wb_rd, in_rs2, wb_data, in_rs2_data);
      d.imm         = in_imm;
      d.rd          = in_rd;
      d.alu_select  = in_alu_select;
      d.op1_sel     = in_op1_sel;
      d.op2_sel     = in_op2_sel;
      d.reg_write   = in_reg_write;
      d.mem_read    = in_mem_read;
      d.mem_write   = in_mem_write;
      d.wb_sel      = in_wb_sel;
      d.branch_ctrl = in_branch_ctrl;
   end

   // While stalled, only the operands may change: a WB write landing on a held source
   // register would otherwise be lost once it retires out of the pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= bubble();
      end else if (stall) begin
         q.rs1_data <= wb_bypass(wb_write_en, wb_rd, q.rs1, wb_data, q.rs1_data);
         q.rs2_data <= wb_bypass(wb_write_en, wb_rd, q.rs2, wb_data, q.rs2_data);
      end else if (flush || load_use_hazard) begin
         q <= bubble();
      end else begin
         q <= d;
      end
   end

   assign alu_data1       = q.op1_sel ? q.pc  : q.rs1_data;
   assign alu_data2       = q.op2_sel ? q.imm : q.rs2_data;
   assign alu_select      = q.alu_select;
   assign out_valid       = q.valid;
   assign out_pc          = q.pc;
   assign out_rs2_data    = q.rs2_data;
   assign out_imm         = q.imm;
   assign out_rd          = q.rd;
   assign out_reg_write   = q.reg_write;
   assign out_mem_read    = q.mem_read;
   assign out_mem_write   = q.mem_write;
   assign out_wb_sel      = q.wb_sel;
   assign out_branch_ctrl = q.branch_ctrl;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: a sequential vector table (state carries row to row)
// followed by a short hand-written sequence for PC operand and MEM/WB control fields.
module tb_id_ex_pipeline_reg;
   import id_ex_pipeline_reg_pkg::*;

   logic               clk = 1'b0;
   logic               reset = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [XLEN-1:0]    in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
   logic [REGADDR-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic [SELW-1:0]    in_alu_select = '0;
   logic               in_op1_sel = 1'b0, in_op2_sel = 1'b0, in_reg_write = 1'b0;
   logic               in_mem_read = 1'b0, in_mem_write = 1'b0;
   logic [1:0]         in_wb_sel = '0;
   logic [3:0]         in_branch_ctrl = '0;
   logic               wb_write_en = 1'b0;
   logic [REGADDR-1:0] wb_rd = '0;
   logic [XLEN-1:0]    wb_data = '0;
   logic [XLEN-1:0]    alu_data1, alu_data2, out_pc, out_rs2_data, out_imm;
   logic [SELW-1:0]    alu_select;
   logic               out_valid, out_reg_write, out_mem_read, out_mem_write, load_use_hazard;
   logic [REGADDR-1:0] out_rd;
   logic [1:0]         out_wb_sel;
   logic [3:0]         out_branch_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_reg dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rd(in_rd),
      .in_alu_select(in_alu_select), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_wb_sel(in_wb_sel), .in_branch_ctrl(in_branch_ctrl),
      .wb_write_en(wb_write_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
      .out_valid(out_valid), .out_pc(out_pc), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_wb_sel(out_wb_sel), .out_branch_ctrl(out_branch_ctrl),
      .load_use_hazard(load_use_hazard)
   );

   typedef struct {
      string              name;
      logic               rst, stl, fl, vld;
      logic [REGADDR-1:0] rs1, rs2, rd;
      logic [XLEN-1:0]    r1d, r2d, imm;
      logic               op2, memr, wbe;
      logic [REGADDR-1:0] wbrd;
      logic [XLEN-1:0]    wbd;
      logic               e_hz, e_valid;
      logic [XLEN-1:0]    e_d1, e_d2, e_r2d;
      logic [REGADDR-1:0] e_rd;
      logic               e_memr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic rst, stl, fl, vld,
                      input logic [4:0] rs1, rs2, rd, input logic [31:0] r1d, r2d, imm,
                      input logic op2, memr, wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
                      input logic e_hz, e_valid, input logic [31:0] e_d1, e_d2, e_r2d,
                      input logic [4:0] e_rd, input logic e_memr);
      vec_t v;
      v.name = nm; v.rst = rst; v.stl = stl; v.fl = fl; v.vld = vld;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1d = r1d; v.r2d = r2d; v.imm = imm;
      v.op2 = op2; v.memr = memr; v.wbe = wbe; v.wbrd = wbrd; v.wbd = wbd;
      v.e_hz = e_hz; v.e_valid = e_valid; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_r2d = e_r2d;
      v.e_rd = e_rd; v.e_memr = e_memr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Valid instructions are driven as SUB with branch code 3, so a bubble is visible as ADD/0.
   task automatic drive(input vec_t v);
      reset = v.rst; stall = v.stl; flush = v.fl; in_valid = v.vld;
      in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
      in_rs1_data = v.r1d; in_rs2_data = v.r2d; in_imm = v.imm; in_pc = 32'h100;
      in_op1_sel = 1'b0; in_op2_sel = v.op2; in_mem_read = v.memr; in_mem_write = 1'b0;
      in_reg_write = v.vld; in_alu_select = v.vld ? ALU_SUB : ALU_ADD;
      in_branch_ctrl = v.vld ? 4'd3 : 4'd0; in_wb_sel = v.memr ? WB_MEM : WB_ALU;
      wb_write_en = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd;
   endtask

   initial begin
      add("reset0",     1,0,0,1, 1,2,5,  32'h7,32'h9,32'hC,   1,0, 0,0,0,          0,0, 0,0,0, 0,0);
      add("reset1",     1,0,0,1, 1,2,5,  32'h7,32'h9,32'hC,   1,0, 0,0,0,          0,0, 0,0,0, 0,0);
      add("addi_x5",    0,0,0,1, 1,0,5,  32'h7,32'h0,32'hC,   1,0, 0,0,0,          0,1, 32'h7,32'hC,32'h0, 5,0);
      add("byp_rs1",    0,0,0,1, 3,2,6,  32'h1,32'h9,32'h0,   0,0, 1,3,32'hDEAD,   0,1, 32'hDEAD,32'h9,32'h9, 6,0);
      add("byp_x0",     0,0,0,1, 0,2,6,  32'h1,32'h9,32'h0,   0,0, 1,0,32'hBEEF,   0,1, 32'h1,32'h9,32'h9, 6,0);
      add("byp_wbe0",   0,0,0,1, 3,2,6,  32'h11,32'h9,32'h0,  0,0, 0,3,32'hDEAD,   0,1, 32'h11,32'h9,32'h9, 6,0);
      add("lw_x4",      0,0,0,1, 1,0,4,  32'h40,32'h0,32'h8,  1,1, 0,0,0,          0,1, 32'h40,32'h8,32'h0, 4,1);
      add("lu_bubble",  0,0,0,1, 4,2,7,  32'h0,32'h5,32'h0,   0,0, 0,0,0,          1,0, 0,0,0, 0,0);
      add("lu_retry",   0,0,0,1, 4,2,7,  32'h0,32'h5,32'h0,   0,0, 1,4,32'h99,     0,1, 32'h99,32'h5,32'h5, 7,0);
      add("add_x8",     0,0,0,1, 1,8,9,  32'h3,32'h20,32'h0,  0,0, 0,0,0,          0,1, 32'h3,32'h20,32'h20, 9,0);
      add("stall_wb8",  0,1,0,1, 2,3,12, 32'hAAAA,32'hBBBB,0, 1,0, 1,8,32'h55,     0,1, 32'h3,32'h55,32'h55, 9,0);
      add("stall_wbx0", 0,1,0,1, 2,3,12, 32'hAAAA,32'hBBBB,0, 1,0, 1,0,32'h1234,   0,1, 32'h3,32'h55,32'h55, 9,0);
      add("stall_hold", 0,1,0,1, 2,3,12, 32'hAAAA,32'hBBBB,0, 1,0, 0,8,32'h77,     0,1, 32'h3,32'h55,32'h55, 9,0);
      add("lw_x10",     0,0,0,1, 1,0,10, 32'h80,32'h0,32'h4,  1,1, 0,0,0,          0,1, 32'h80,32'h4,32'h0, 10,1);
      add("flush_stall",0,1,1,1, 10,0,11,32'h5,32'h6,32'h0,   0,0, 0,0,0,          0,1, 32'h80,32'h4,32'h0, 10,1);
      add("flush_hz",   0,0,1,1, 10,0,11,32'h5,32'h6,32'h0,   0,0, 0,0,0,          0,0, 0,0,0, 0,0);
      add("lw_x10b",    0,0,0,1, 1,0,10, 32'h80,32'h0,32'h4,  1,1, 0,0,0,          0,1, 32'h80,32'h4,32'h0, 10,1);
      add("stall_hz",   0,1,0,1, 10,0,11,32'h5,32'h6,32'h0,   0,0, 0,0,0,          1,1, 32'h80,32'h4,32'h0, 10,1);
      add("hz_rs2",     0,0,0,1, 0,10,11,32'h5,32'h6,32'h0,   0,0, 0,0,0,          1,0, 0,0,0, 0,0);
      add("lw_x10c",    0,0,0,1, 1,0,10, 32'h80,32'h0,32'h4,  1,1, 0,0,0,          0,1, 32'h80,32'h4,32'h0, 10,1);
      add("hz_novalid", 0,0,0,0, 10,0,0, 32'h0,32'h0,32'h0,   0,0, 0,0,0,          0,0, 0,0,0, 0,0);
      add("lw_x0",      0,0,0,1, 1,0,0,  32'h50,32'h0,32'h4,  1,1, 0,0,0,          0,1, 32'h50,32'h4,32'h0, 0,1);
      add("x0_nohz",    0,0,0,1, 0,0,1,  32'h0,32'h0,32'h5,   1,0, 0,0,0,          0,1, 32'h0,32'h5,32'h0, 1,0);
      add("pre_rst",    0,0,0,1, 1,2,3,  32'h6,32'h7,32'h0,   0,0, 0,0,0,          0,1, 32'h6,32'h7,32'h7, 3,0);
      add("rst_mid",    1,0,0,1, 1,2,3,  32'h6,32'h7,32'h0,   0,0, 0,0,0,          0,0, 0,0,0, 0,0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk({vecs[i].name, ".hazard"}, 32'(load_use_hazard), 32'(vecs[i].e_hz));
         @(posedge clk);
         #1;
         chk({vecs[i].name, ".valid"},  32'(out_valid),     32'(vecs[i].e_valid));
         chk({vecs[i].name, ".data1"},  alu_data1,          vecs[i].e_d1);
         chk({vecs[i].name, ".data2"},  alu_data2,          vecs[i].e_d2);
         chk({vecs[i].name, ".rs2d"},   out_rs2_data,       vecs[i].e_r2d);
         chk({vecs[i].name, ".rd"},     32'(out_rd),        32'(vecs[i].e_rd));
         chk({vecs[i].name, ".regw"},   32'(out_reg_write), 32'(vecs[i].e_valid));
         chk({vecs[i].name, ".memr"},   32'(out_mem_read),  32'(vecs[i].e_memr));
         chk({vecs[i].name, ".sel"},    32'(alu_select),    32'(vecs[i].e_valid ? ALU_SUB : ALU_ADD));
         chk({vecs[i].name, ".br"},     32'(out_branch_ctrl), vecs[i].e_valid ? 32'd3 : 32'd0);
      end

      // PC-relative operand and store/WB-select fields
      @(negedge clk);
      reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; wb_write_en = 1'b0;
      in_pc = 32'h200; in_imm = 32'h1000; in_op1_sel = 1'b1; in_op2_sel = 1'b1;
      in_rs1 = 5'd1; in_rs2 = 5'd2; in_rs1_data = 32'h11; in_rs2_data = 32'h22; in_rd = 5'd0;
      in_mem_read = 1'b0; in_mem_write = 1'b1; in_wb_sel = WB_PC4; in_alu_select = ALU_XOR;
      @(posedge clk);
      #1;
      chk("auipc.data1", alu_data1, 32'h200);
      chk("auipc.data2", alu_data2, 32'h1000);
      chk("auipc.pc",    out_pc, 32'h200);
      chk("auipc.imm",   out_imm, 32'h1000);
      chk("auipc.rs2d",  out_rs2_data, 32'h22);
      chk("auipc.memw",  32'(out_mem_write), 32'd1);
      chk("auipc.wbsel", 32'(out_wb_sel), 32'(WB_PC4));
      chk("auipc.sel",   32'(alu_select), 32'(ALU_XOR));

      // Flush with no hazard clears every data and control field
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush.pc",    out_pc, 32'h0);
      chk("flush.imm",   out_imm, 32'h0);
      chk("flush.data1", alu_data1, 32'h0);
      chk("flush.memw",  32'(out_mem_write), 32'd0);
      chk("flush.wbsel", 32'(out_wb_sel), 32'd0);
      chk("flush.sel",   32'(alu_select), 32'(ALU_ADD));
      chk("flush.valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
